// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: page decoder, chip-select generator and read mux between the
// FemtoRV32 memory port and NSLV peripheral slots. Adds per-slave wait states,
// a timeout watchdog, unmapped-access detection and a clearable error status
// register mapped at STAT_PAGE.
//
// Handshake: a CPU strobe (cpu_rstrb or |cpu_wmask) is accepted in IDLE, or in
// WAIT on the completion cycle (busy low). On acceptance slv_rd/slv_wr pulse for
// exactly one cycle. While busy is high the CPU holds its request, and any strobe
// it presents is ignored. The completion cycle is the first WAIT cycle with busy
// low; read data is valid on that cycle.
module periph_bus_ctrl #(
    parameter int          NSLV      = 8,
    parameter logic [15:0] BASE_PAGE = 16'h0040,
    parameter logic [15:0] STAT_PAGE = 16'h00FF,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    input  logic [3:0]           cpu_wmask,
    input  logic                 cpu_rstrb,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_rbusy,
    output logic                 cpu_wbusy,
    output logic [NSLV-1:0]      slv_cs,
    output logic                 slv_rd,
    output logic                 slv_wr,
    input  logic [32*NSLV-1:0]   slv_rdata,
    input  logic [NSLV-1:0]      slv_ready,
    output logic                 err_irq,
    output logic [1:0]           dbg_state
);

    localparam int          SW     = $clog2(NSLV);
    localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
    } state_t;

    typedef enum logic [1:0] {
        TGT_SLV  = 2'd0,
        TGT_STAT = 2'd1,
        TGT_UNM  = 2'd2
    } tgt_t;

    state_t        r_state;
    state_t        w_next;
    tgt_t          r_tgt_q;
    tgt_t          w_tgt;
    logic [SW-1:0] r_sel_q;
    logic [SW-1:0] w_slot;
    logic          r_wr_q;
    logic [7:0]    r_page_q;
    logic [15:0]   r_wait_cnt;
    logic          r_err_flag;
    logic [15:0]   r_err_count;
    logic [7:0]    r_last_page;
    logic [31:0]   r_rdata_q;

    logic [15:0]   w_page;
    logic [15:0]   w_off;
    logic          w_strobe;
    logic          w_is_wr;
    logic          w_timeout;
    logic          w_busy;
    logic          w_done;
    logic          w_accept;
    logic          w_err_new;
    logic [7:0]    w_err_page;
    logic          w_clr;
    logic [31:0]   w_rdata;
    logic [31:0]   w_status;

    assign w_page   = cpu_addr[31:16];
    assign w_off    = w_page - BASE_PAGE;
    assign w_strobe = cpu_rstrb | (|cpu_wmask);
    assign w_is_wr  = |cpu_wmask;

    // Page decode of the live CPU address into target kind and slot index
    always_comb begin
        w_tgt  = TGT_UNM;
        w_slot = '0;
        if (w_page == 16'h0000) begin
            w_tgt  = TGT_SLV;
            w_slot = '0;
        end else if (w_page == STAT_PAGE) begin
            w_tgt = TGT_STAT;
        end else if ((w_page >= BASE_PAGE) && (w_off <= 16'(NSLV - 2))) begin
            w_tgt  = TGT_SLV;
            w_slot = w_off[SW-1:0] + SW'(1);
        end
    end

    // Watchdog fires once the busy counter has reached TIMEOUT; that cycle completes
    assign w_timeout = (r_state == WAIT) && (r_wait_cnt == TO_VAL);
    assign w_busy    = (r_state == WAIT) && (r_tgt_q == TGT_SLV) &&
                       !slv_ready[r_sel_q] && !w_timeout;
    assign w_done    = (r_state == WAIT) && !w_busy;
    assign w_accept  = w_strobe && ((r_state == IDLE) || w_done);

    assign cpu_rbusy = w_busy && !r_wr_q;
    assign cpu_wbusy = w_busy && r_wr_q;
    assign slv_rd    = w_accept && cpu_rstrb;
    assign slv_wr    = w_accept && w_is_wr;
    assign err_irq   = r_err_flag;
    assign dbg_state = r_state;

    // Error sources: unmapped access at accept, or watchdog expiry at completion.
    // Unmapped page takes precedence for last_err_page if both land together.
    assign w_err_new  = (w_accept && (w_tgt == TGT_UNM)) || w_timeout;
    assign w_err_page = (w_accept && (w_tgt == TGT_UNM)) ? w_page[7:0] : r_page_q;
    assign w_clr      = w_accept && w_is_wr && (w_tgt == TGT_STAT);

    assign w_status = {r_err_count, 7'b0, r_err_flag, r_last_page};

    // Next-state logic: accept wins over completion so back-to-back stays in WAIT
    always_comb begin
        w_next = r_state;
        if (w_accept) begin
            w_next = WAIT;
        end else if (w_done) begin
            w_next = IDLE;
        end
    end

    // Chip selects: live decode on accept, latched slot in WAIT, RAM slot when idle
    always_comb begin
        slv_cs = '0;
        if (w_accept) begin
            if (w_tgt == TGT_SLV) begin
                slv_cs[w_slot] = 1'b1;
            end
        end else if (r_state == WAIT) begin
            if (r_tgt_q == TGT_SLV) begin
                slv_cs[r_sel_q] = 1'b1;
            end
        end else begin
            slv_cs[0] = 1'b1;
        end
    end

    // Read mux: live data in WAIT, last completed data held while idle
    always_comb begin
        w_rdata = r_rdata_q;
        if (r_state == WAIT) begin
            if (w_timeout || (r_tgt_q == TGT_UNM)) begin
                w_rdata = ERR_DATA;
            end else if (r_tgt_q == TGT_STAT) begin
                w_rdata = w_status;
            end else begin
                w_rdata = slv_rdata[int'(r_sel_q)*32 +: 32];
            end
        end
    end
    assign cpu_rdata = w_rdata;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Transaction capture, wait counter and completion data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tgt_q    <= TGT_SLV;
            r_sel_q    <= '0;
            r_wr_q     <= 1'b0;
            r_page_q   <= 8'h00;
            r_wait_cnt <= 16'h0000;
            r_rdata_q  <= 32'h0000_0000;
        end else begin
            if (w_done) begin
                r_rdata_q <= w_rdata;
            end
            if (w_accept) begin
                r_tgt_q    <= w_tgt;
                r_sel_q    <= w_slot;
                r_wr_q     <= w_is_wr;
                r_page_q   <= w_page[7:0];
                r_wait_cnt <= 16'h0000;
            end else if (w_busy) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
        end
    end

    // Error status: a status write clears everything including the last page,
    // but an error arriving in the same cycle restarts the log at one
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_flag  <= 1'b0;
            r_err_count <= 16'h0000;
            r_last_page <= 8'h00;
        end else if (w_clr) begin
            r_err_flag  <= w_err_new;
            r_err_count <= w_err_new ? 16'h0001 : 16'h0000;
            r_last_page <= w_err_new ? w_err_page : 8'h00;
        end else if (w_err_new) begin
            r_err_flag  <= 1'b1;
            r_last_page <= w_err_page;
            if (r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    // Write data goes straight to the slaves; it is not used internally
    logic w_unused;
    assign w_unused = ^cpu_wdata;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed bench for periph_bus_ctrl: a vector table of zero-wait transactions
// followed by hand-written wait-state, timeout, error-log and reset sequences.
module tb_periph_bus_ctrl;

  localparam int NSLV = 8;

  logic                clk;
  logic                resetn;
  logic [31:0]         cpu_addr;
  logic [31:0]         cpu_wdata;
  logic [3:0]          cpu_wmask;
  logic                cpu_rstrb;
  logic [31:0]         cpu_rdata;
  logic                cpu_rbusy;
  logic                cpu_wbusy;
  logic [NSLV-1:0]     slv_cs;
  logic                slv_rd;
  logic                slv_wr;
  logic [32*NSLV-1:0]  slv_rdata;
  logic [NSLV-1:0]     slv_ready;
  logic                err_irq;
  logic [1:0]          dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  periph_bus_ctrl #(
    .NSLV(NSLV),
    .BASE_PAGE(16'h0040),
    .STAT_PAGE(16'h00FF),
    .TIMEOUT(16),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_wmask(cpu_wmask),
    .cpu_rstrb(cpu_rstrb),
    .cpu_rdata(cpu_rdata),
    .cpu_rbusy(cpu_rbusy),
    .cpu_wbusy(cpu_wbusy),
    .slv_cs(slv_cs),
    .slv_rd(slv_rd),
    .slv_wr(slv_wr),
    .slv_rdata(slv_rdata),
    .slv_ready(slv_ready),
    .err_irq(err_irq),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic        rstrb;
    logic [7:0]  exp_cs;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // advance to the drive point of the next cycle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // move to mid-cycle, where outputs are sampled
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    cpu_rstrb = 1'b0;
    cpu_wmask = 4'h0;
  endtask

  // zero-wait read; checks data and busy on the completion cycle
  task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
    cpu_addr  = addr;
    cpu_rstrb = 1'b1;
    cyc();
    idle_bus();
    mid();
    chk({name, "_busy"}, {31'b0, cpu_rbusy}, 32'd0);
    chk({name, "_data"}, cpu_rdata, exp);
    cyc();
  endtask

  task automatic do_write(input logic [31:0] addr);
    cpu_addr  = addr;
    cpu_wmask = 4'hF;
    cpu_wdata = 32'h5555_AAAA;
    cyc();
    idle_bus();
    cyc();
  endtask

  initial begin
    resetn    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_wmask = 4'h0;
    cpu_rstrb = 1'b0;
    slv_ready = '1;
    for (int i = 0; i < NSLV; i++) slv_rdata[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
    slv_rdata[32*3 +: 32] = 32'h1234_5678;

    vecs[0] = '{"rd_slot3",  32'h0042_0004, 4'h0, 1'b1, 8'b0000_1000, 32'h1234_5678};
    vecs[1] = '{"rd_slot0",  32'h0000_0010, 4'h0, 1'b1, 8'b0000_0001, 32'hC0DE_0000};
    vecs[2] = '{"rd_slot7",  32'h0046_0000, 4'h0, 1'b1, 8'b1000_0000, 32'hC0DE_0007};
    vecs[3] = '{"rd_slot1",  32'h0040_0100, 4'h0, 1'b1, 8'b0000_0010, 32'hC0DE_0001};
    vecs[4] = '{"wr_slot2",  32'h0041_0000, 4'hF, 1'b0, 8'b0000_0100, 32'hC0DE_0002};
    vecs[5] = '{"wr_slot6",  32'h0045_0008, 4'h3, 1'b0, 8'b0100_0000, 32'hC0DE_0006};

    // reset state
    repeat (2) @(posedge clk);
    mid();
    chk("rst_cs", {24'b0, slv_cs}, 32'h01);
    chk("rst_rbusy", {31'b0, cpu_rbusy}, 32'd0);
    chk("rst_wbusy", {31'b0, cpu_wbusy}, 32'd0);
    chk("rst_irq", {31'b0, err_irq}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc();

    // table-driven zero-wait transactions
    for (int v = 0; v < 6; v++) begin
      cpu_addr  = vecs[v].addr;
      cpu_wmask = vecs[v].wmask;
      cpu_rstrb = vecs[v].rstrb;
      mid();
      chk({vecs[v].name, "_cs"}, {24'b0, slv_cs}, {24'b0, vecs[v].exp_cs});
      chk({vecs[v].name, "_rd"}, {31'b0, slv_rd}, {31'b0, vecs[v].rstrb});
      chk({vecs[v].name, "_wr"}, {31'b0, slv_wr}, {31'b0, (vecs[v].wmask != 4'h0)});
      cyc();
      idle_bus();
      mid();
      chk({vecs[v].name, "_busy"}, {30'b0, cpu_rbusy, cpu_wbusy}, 32'd0);
      chk({vecs[v].name, "_cs_wait"}, {24'b0, slv_cs}, {24'b0, vecs[v].exp_cs});
      chk({vecs[v].name, "_rdata"}, cpu_rdata, vecs[v].exp_rdata);
      cyc();
      mid();
      chk({vecs[v].name, "_idle_cs"}, {24'b0, slv_cs}, 32'h01);
      cyc();
    end

    do_read("stat_init", 32'h00FF_0000, 32'h0000_0000);

    // waited read of slot 2, stray strobe while busy, back-to-back in completion cycle
    slv_ready[2] = 1'b0;
    cpu_addr  = 32'h0041_0000;
    cpu_rstrb = 1'b1;
    mid();
    chk("wt_rd_pulse", {31'b0, slv_rd}, 32'd1);
    cyc();
    idle_bus();
    for (int k = 1; k <= 5; k++) begin
      if (k == 3) begin
        cpu_addr  = 32'h0044_0000;
        cpu_rstrb = 1'b1;
      end
      mid();
      chk($sformatf("wt_rbusy_%0d", k), {31'b0, cpu_rbusy}, 32'd1);
      chk($sformatf("wt_norpulse_%0d", k), {31'b0, slv_rd}, 32'd0);
      chk($sformatf("wt_cs_%0d", k), {24'b0, slv_cs}, 32'h04);
      cyc();
      idle_bus();
    end
    slv_ready[2] = 1'b1;
    cpu_addr  = 32'h0044_0000;
    cpu_rstrb = 1'b1;
    mid();
    chk("wt_done_busy", {31'b0, cpu_rbusy}, 32'd0);
    chk("wt_done_data", cpu_rdata, 32'hC0DE_0002);
    chk("b2b_pulse", {31'b0, slv_rd}, 32'd1);
    chk("b2b_cs", {24'b0, slv_cs}, 32'h20);
    cyc();
    idle_bus();
    mid();
    chk("b2b_busy", {31'b0, cpu_rbusy}, 32'd0);
    chk("b2b_data", cpu_rdata, 32'hC0DE_0005);
    chk("b2b_nopulse", {31'b0, slv_rd}, 32'd0);
    cyc();

    // write timeout on slot 4
    slv_ready[4] = 1'b0;
    cpu_addr  = 32'h0043_0000;
    cpu_wmask = 4'hF;
    mid();
    chk("to_wr_pulse", {31'b0, slv_wr}, 32'd1);
    cyc();
    idle_bus();
    for (int k = 1; k <= 16; k++) begin
      mid();
      chk($sformatf("to_wbusy_%0d", k), {31'b0, cpu_wbusy}, 32'd1);
      cyc();
    end
    mid();
    chk("to_release", {31'b0, cpu_wbusy}, 32'd0);
    cyc();
    mid();
    chk("to_irq", {31'b0, err_irq}, 32'd1);
    cyc();
    slv_ready[4] = 1'b1;
    do_read("to_stat", 32'h00FF_0000, 32'h0001_0143);

    // unmapped reads, including the page just past the last slot
    do_read("unm90", 32'h0090_0000, 32'hDEAD_BEEF);
    do_read("unm90_stat", 32'h00FF_0000, 32'h0002_0190);
    do_read("unm47", 32'h0047_0000, 32'hDEAD_BEEF);
    do_read("unm47_stat", 32'h00FF_0000, 32'h0003_0147);

    // status write clears the log
    do_write(32'h00FF_0000);
    mid();
    chk("clr_irq", {31'b0, err_irq}, 32'd0);
    cyc();
    do_read("clr_stat", 32'h00FF_0000, 32'h0000_0000);

    // reset in the middle of a waited read
    do_read("pre_rst_unm", 32'h0090_0000, 32'hDEAD_BEEF);
    slv_ready[6] = 1'b0;
    cpu_addr  = 32'h0045_0000;
    cpu_rstrb = 1'b1;
    cyc();
    idle_bus();
    cyc();
    mid();
    chk("prerst_busy", {31'b0, cpu_rbusy}, 32'd1);
    chk("prerst_irq", {31'b0, err_irq}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, cpu_rbusy}, 32'd0);
    chk("rst_mid_irq", {31'b0, err_irq}, 32'd0);
    chk("rst_mid_cs", {24'b0, slv_cs}, 32'h01);
    chk("rst_mid_state", {30'b0, dbg_state}, 32'd0);
    @(posedge clk);
    #3;
    resetn = 1'b1;
    slv_ready[6] = 1'b1;
    cyc();
    do_read("post_rst_ram", 32'h0000_0020, 32'hC0DE_0000);
    do_read("post_rst_stat", 32'h00FF_0000, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // watchdog on overall run length
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
